// File: rtl/xtea_pkg.sv
// Shared widths, FSM state encoding and word-slot mapping for the XTEA word driver.
package xtea_pkg;

   localparam int unsigned WORDS   = 4;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned BLOCK_W = 128;
   localparam int unsigned IDX_W   = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_KEY,
      ST_LOAD_DATA,
      ST_START,
      ST_WAIT_CORE,
      ST_SEND
   } state_t;

   // Word 0 of a group lives in the most-significant slot of the block.
   function automatic logic [IDX_W-1:0] word_slot(input logic [IDX_W-1:0] idx);
      return IDX_W'(WORDS - 1) - idx;
   endfunction

endpackage

// File: rtl/xtea_word_sreg.sv
// 4x32 word buffer: indexed write, indexed read, parallel load and synchronous clear.
module xtea_word_sreg
   import xtea_pkg::*;
(
   input  logic               clock,
   input  logic               clear,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_idx,
   input  logic [WORD_W-1:0]  wr_data,
   input  logic               load_en,
   input  logic [BLOCK_W-1:0] load_data,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic [WORD_W-1:0]  rd_data,
   output logic [BLOCK_W-1:0] block
);

   logic [WORDS-1:0][WORD_W-1:0] mem;

   always_ff @(posedge clock) begin
      if (clear) begin
         mem <= '0;
      end else if (load_en) begin
         mem <= load_data;
      end else if (wr_en) begin
         mem[word_slot(wr_idx)] <= wr_data;
      end
   end

   assign rd_data = mem[word_slot(rd_idx)];
   assign block   = mem;

endmodule

// File: rtl/xtea_word_driver.sv
// Host-side initiator for the XTEA core: gathers key/data words, starts the core,
// waits for its result with a timeout and streams the result back as four words.
module xtea_word_driver
   import xtea_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [WORD_W-1:0]  word_in,
   input  logic               word_valid,
   output logic               word_ready,
   input  logic               mode_in,
   input  logic               key_keep,
   output logic [WORD_W-1:0]  out_word,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic               err,
   output logic [BLOCK_W-1:0] core_data_i,
   output logic [BLOCK_W-1:0] core_key,
   output logic               core_configuration,
   output logic               core_start,
   input  logic               core_ready,
   input  logic [BLOCK_W-1:0] core_data_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               key_valid;

   logic               xfer;
   logic               key_reuse;
   logic               key_wr;
   logic               data_wr;
   logic [IDX_W-1:0]   wr_idx;
   logic [IDX_W-1:0]   rd_idx;
   logic               res_load;
   logic               timeout;
   logic [WORD_W-1:0]  res_word;

   logic [WORD_W-1:0]  key_rd_unused;
   logic [WORD_W-1:0]  data_rd_unused;
   logic [BLOCK_W-1:0] res_block_unused;

   assign word_ready = !reset &&
                       (state == ST_IDLE || state == ST_LOAD_KEY || state == ST_LOAD_DATA);
   assign xfer       = word_valid && word_ready;
   assign key_reuse  = key_keep && key_valid;
   assign busy       = (state != ST_IDLE);
   assign cnt_nxt    = cnt + CNT_W'(1);
   assign res_load   = (state == ST_WAIT_CORE) && core_ready;
   // Counting the current WAIT cycle gives at most TIMEOUT_CYCLES cycles from start to ready.
   assign timeout    = (state == ST_WAIT_CORE) && !core_ready && (cnt_nxt == CNT_W'(TIMEOUT_CYCLES));
   // Look one word ahead so the output register holds the next word after a handshake.
   assign rd_idx     = idx + IDX_W'(1);

   // Steer accepted words into the key or data buffer.
   always_comb begin
      key_wr  = 1'b0;
      data_wr = 1'b0;
      wr_idx  = idx;
      case (state)
         ST_IDLE: begin
            wr_idx  = '0;
            key_wr  = xfer && !key_reuse;
            data_wr = xfer && key_reuse;
         end
         ST_LOAD_KEY:  key_wr  = xfer;
         ST_LOAD_DATA: data_wr = xfer;
         default: ;
      endcase
   end

   xtea_word_sreg u_key (
      .clock     (clock),
      .clear     (reset),
      .wr_en     (key_wr),
      .wr_idx    (wr_idx),
      .wr_data   (word_in),
      .load_en   (1'b0),
      .load_data ('0),
      .rd_idx    ('0),
      .rd_data   (key_rd_unused),
      .block     (core_key)
   );

   xtea_word_sreg u_data (
      .clock     (clock),
      .clear     (reset),
      .wr_en     (data_wr),
      .wr_idx    (wr_idx),
      .wr_data   (word_in),
      .load_en   (1'b0),
      .load_data ('0),
      .rd_idx    ('0),
      .rd_data   (data_rd_unused),
      .block     (core_data_i)
   );

   xtea_word_sreg u_result (
      .clock     (clock),
      .clear     (reset || timeout),
      .wr_en     (1'b0),
      .wr_idx    ('0),
      .wr_data   ('0),
      .load_en   (res_load),
      .load_data (core_data_o),
      .rd_idx    (rd_idx),
      .rd_data   (res_word),
      .block     (res_block_unused)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state              <= ST_IDLE;
         idx                <= '0;
         cnt                <= '0;
         key_valid          <= 1'b0;
         err                <= 1'b0;
         core_start         <= 1'b0;
         core_configuration <= 1'b0;
         out_valid          <= 1'b0;
         out_word           <= '0;
      end else begin
         core_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  core_configuration <= mode_in;
                  err                <= 1'b0;
                  idx                <= IDX_W'(1);
                  if (key_reuse) begin
                     state <= ST_LOAD_DATA;
                  end else begin
                     key_valid <= 1'b0;
                     state     <= ST_LOAD_KEY;
                  end
               end
            end
            ST_LOAD_KEY: begin
               if (xfer) begin
                  idx <= idx + IDX_W'(1);
                  if (idx == IDX_W'(WORDS - 1)) begin
                     key_valid <= 1'b1;
                     state     <= ST_LOAD_DATA;
                  end
               end
            end
            ST_LOAD_DATA: begin
               if (xfer) begin
                  idx <= idx + IDX_W'(1);
                  if (idx == IDX_W'(WORDS - 1)) begin
                     core_start <= 1'b1;
                     state      <= ST_START;
                  end
               end
            end
            ST_START: begin
               cnt   <= '0;
               state <= ST_WAIT_CORE;
            end
            ST_WAIT_CORE: begin
               cnt <= cnt_nxt;
               if (core_ready) begin
                  out_word  <= core_data_o[BLOCK_W-1 -: WORD_W];
                  out_valid <= 1'b1;
                  idx       <= '0;
                  state     <= ST_SEND;
               end else if (timeout) begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            ST_SEND: begin
               if (out_ready) begin
                  idx <= idx + IDX_W'(1);
                  if (idx == IDX_W'(WORDS - 1)) begin
                     out_valid <= 1'b0;
                     state     <= ST_IDLE;
                  end else begin
                     out_word <= res_word;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xtea_word_driver.sv
// Directed bench for xtea_word_driver: a default-timeout instance and a 16-cycle-timeout
// instance share host stimulus and one XOR stub core, selected by sel.
module tb_xtea_word_driver;

   logic         clock;
   logic         reset;
   logic [31:0]  word_in;
   logic         word_valid;
   logic         mode_in;
   logic         key_keep;
   logic         out_ready;
   logic         sel;

   logic         word_ready_a, word_ready_b;
   logic [31:0]  out_word_a, out_word_b;
   logic         out_valid_a, out_valid_b;
   logic         busy_a, busy_b;
   logic         err_a, err_b;
   logic [127:0] cdi_a, cdi_b, ckey_a, ckey_b;
   logic         cconf_a, cconf_b;
   logic         cs_a, cs_b;

   logic         stub_ready;
   logic [127:0] stub_data;
   int           stub_delay;
   bit           stub_never;
   bit           stub_armed;
   int           stub_cnt;

   int           n_tests;
   int           n_fail;
   int           n;
   int           k;
   int           c;
   bit           orr;

   localparam logic [31:0] T1_IN  [8] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                                          32'h41424344, 32'h45464748, 32'h00000000, 32'h00000000};
   localparam logic [31:0] T1_EXP [4] = '{32'h41434147, 32'h4143414F, 32'h08090A0B, 32'h0C0D0E0F};
   localparam logic [31:0] T2_IN  [4] = '{32'h01234567, 32'h89ABCDEF, 32'h00000000, 32'hFFFFFFFF};
   localparam logic [31:0] T2_EXP [4] = '{32'h01224764, 32'h8DAECBE8, 32'h08090A0B, 32'hF3F2F1F0};
   localparam logic [31:0] T4_IN  [8] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                          32'hAAAAAAAA, 32'h55555555, 32'h12345678, 32'h00000000};
   localparam logic [31:0] T4_EXP [4] = '{32'hBBBBBBBB, 32'h77777777, 32'h2107654B, 32'h44444444};

   wire          word_valid_a = word_valid & ~sel;
   wire          word_valid_b = word_valid & sel;
   wire          wr_m   = sel ? word_ready_b : word_ready_a;
   wire [31:0]   ow_m   = sel ? out_word_b   : out_word_a;
   wire          ov_m   = sel ? out_valid_b  : out_valid_a;
   wire          busy_m = sel ? busy_b       : busy_a;
   wire          err_m  = sel ? err_b        : err_a;
   wire [127:0]  cdi_m  = sel ? cdi_b        : cdi_a;
   wire [127:0]  ckey_m = sel ? ckey_b       : ckey_a;
   wire          cconf_m = sel ? cconf_b     : cconf_a;
   wire          cs_m   = sel ? cs_b         : cs_a;

   xtea_word_driver u_dut_a (
      .clock              (clock),
      .reset              (reset),
      .word_in            (word_in),
      .word_valid         (word_valid_a),
      .word_ready         (word_ready_a),
      .mode_in            (mode_in),
      .key_keep           (key_keep),
      .out_word           (out_word_a),
      .out_valid          (out_valid_a),
      .out_ready          (out_ready),
      .busy               (busy_a),
      .err                (err_a),
      .core_data_i        (cdi_a),
      .core_key           (ckey_a),
      .core_configuration (cconf_a),
      .core_start         (cs_a),
      .core_ready         (stub_ready & ~sel),
      .core_data_o        (stub_data)
   );

   xtea_word_driver #(.TIMEOUT_CYCLES(16)) u_dut_b (
      .clock              (clock),
      .reset              (reset),
      .word_in            (word_in),
      .word_valid         (word_valid_b),
      .word_ready         (word_ready_b),
      .mode_in            (mode_in),
      .key_keep           (key_keep),
      .out_word           (out_word_b),
      .out_valid          (out_valid_b),
      .out_ready          (out_ready),
      .busy               (busy_b),
      .err                (err_b),
      .core_data_i        (cdi_b),
      .core_key           (ckey_b),
      .core_configuration (cconf_b),
      .core_start         (cs_b),
      .core_ready         (stub_ready & sel),
      .core_data_o        (stub_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Stub core: ready pulse stub_delay cycles after the start cycle, result = data ^ key.
   always @(posedge clock) begin
      stub_ready <= 1'b0;
      if (reset) begin
         stub_armed <= 1'b0;
      end else if (cs_m) begin
         stub_armed <= 1'b1;
         stub_cnt   <= 1;
         stub_data  <= cdi_m ^ ckey_m;
         if (stub_delay == 1 && !stub_never) begin
            stub_ready <= 1'b1;
            stub_armed <= 1'b0;
         end
      end else if (stub_armed) begin
         stub_cnt <= stub_cnt + 1;
         if (!stub_never && stub_cnt + 1 == stub_delay) begin
            stub_ready <= 1'b1;
            stub_armed <= 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_out_valid(input string tag, input int exp_lat);
      n = 1;
      while (!ov_m && n < 200) begin
         tick();
         n++;
      end
      check(tag, 128'(n), 128'(exp_lat));
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      reset      = 1'b1;
      sel        = 1'b0;
      word_valid = 1'b0;
      word_in    = '0;
      mode_in    = 1'b0;
      key_keep   = 1'b0;
      out_ready  = 1'b0;
      stub_delay = 70;
      stub_never = 1'b0;
      tick();
      tick();

      check("rst_word_ready", 128'(wr_m), 128'(0));
      check("rst_busy", 128'(busy_m), 128'(0));
      check("rst_err", 128'(err_m), 128'(0));
      check("rst_start", 128'(cs_m), 128'(0));
      check("rst_out_valid", 128'(ov_m), 128'(0));
      check("rst_out_word", 128'(ow_m), 128'(0));
      check("rst_data_i", cdi_m, 128'(0));
      check("rst_key", ckey_m, 128'(0));
      check("rst_conf", 128'(cconf_m), 128'(0));
      reset = 1'b0;
      #1;
      check("idle_word_ready", 128'(wr_m), 128'(1));

      // Full key + data load, encrypt
      mode_in  = 1'b1;
      key_keep = 1'b0;
      for (int i = 0; i < 8; i++) begin
         word_valid = 1'b1;
         word_in    = T1_IN[i];
         tick();
         if (i == 0) check("t1_busy_rise", 128'(busy_m), 128'(1));
      end
      word_valid = 1'b0;
      check("t1_start", 128'(cs_m), 128'(1));
      check("t1_key", ckey_m, 128'h000102030405060708090A0B0C0D0E0F);
      check("t1_data_i", cdi_m, 128'h41424344454647480000000000000000);
      check("t1_conf", 128'(cconf_m), 128'(1));
      check("t1_no_accept", 128'(wr_m), 128'(0));
      out_ready = 1'b1;
      tick();
      check("t1_start_pulse", 128'(cs_m), 128'(0));
      wait_out_valid("t1_latency", 71);
      check("t1_key_stable", ckey_m, 128'h000102030405060708090A0B0C0D0E0F);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t1_out_w%0d", i), 128'(ow_m), 128'(T1_EXP[i]));
         tick();
      end
      check("t1_out_done", 128'(ov_m), 128'(0));
      check("t1_busy_fall", 128'(busy_m), 128'(0));

      // Key reuse, decrypt, with output backpressure
      stub_delay = 5;
      mode_in    = 1'b0;
      key_keep   = 1'b1;
      out_ready  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         word_valid = 1'b1;
         word_in    = T2_IN[i];
         tick();
         if (i == 2) check("t2_no_early_start", 128'(cs_m), 128'(0));
      end
      word_valid = 1'b0;
      check("t2_start", 128'(cs_m), 128'(1));
      check("t2_key_kept", ckey_m, 128'h000102030405060708090A0B0C0D0E0F);
      check("t2_conf", 128'(cconf_m), 128'(0));
      check("t2_data_i", cdi_m, 128'h0123456789ABCDEF00000000FFFFFFFF);
      tick();
      wait_out_valid("t2_latency", 6);
      k   = 0;
      c   = 0;
      orr = 1'b0;
      while (ov_m && k < 4 && c < 20) begin
         check($sformatf("t2_bp_w%0d", k), 128'(ow_m), 128'(T2_EXP[k]));
         out_ready = orr;
         tick();
         if (orr) k++;
         orr = ~orr;
         c++;
      end
      check("t2_xfer_count", 128'(k), 128'(4));
      check("t2_out_done", 128'(ov_m), 128'(0));
      check("t2_busy_fall", 128'(busy_m), 128'(0));

      // Timeout on the 16-cycle instance
      sel        = 1'b1;
      stub_never = 1'b1;
      mode_in    = 1'b1;
      key_keep   = 1'b0;
      out_ready  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         word_valid = 1'b1;
         word_in    = T1_IN[i];
         tick();
      end
      word_valid = 1'b0;
      check("t3_start", 128'(cs_m), 128'(1));
      for (int i = 1; i <= 17; i++) begin
         tick();
         if (i == 16) begin
            check("t3_busy_before", 128'(busy_m), 128'(1));
            check("t3_err_before", 128'(err_m), 128'(0));
         end
      end
      check("t3_busy_after", 128'(busy_m), 128'(0));
      check("t3_err_set", 128'(err_m), 128'(1));
      check("t3_no_output", 128'(ov_m), 128'(0));
      word_valid = 1'b1;
      word_in    = T4_IN[0];
      tick();
      check("t3_err_clear", 128'(err_m), 128'(0));

      // Reset while presenting data word 2
      for (int i = 1; i < 6; i++) begin
         word_in = T4_IN[i];
         tick();
      end
      word_in = T4_IN[6];
      reset   = 1'b1;
      tick();
      check("t5_rst_busy", 128'(busy_m), 128'(0));
      check("t5_rst_key", ckey_m, 128'(0));
      check("t5_rst_data_i", cdi_m, 128'(0));
      check("t5_rst_word_ready", 128'(wr_m), 128'(0));
      check("t5_rst_start", 128'(cs_m), 128'(0));
      reset      = 1'b0;
      word_valid = 1'b0;
      tick();

      // key_keep after reset still loads a key; core_ready on the timeout cycle wins
      stub_never = 1'b0;
      stub_delay = 16;
      key_keep   = 1'b1;
      for (int i = 0; i < 8; i++) begin
         word_valid = 1'b1;
         word_in    = T4_IN[i];
         tick();
         if (i == 3) check("t5_full_key_load", 128'(cs_m), 128'(0));
      end
      word_valid = 1'b0;
      check("t5_start", 128'(cs_m), 128'(1));
      check("t5_key", ckey_m, 128'h11111111222222223333333344444444);
      tick();
      wait_out_valid("t6_latency", 17);
      check("t6_err", 128'(err_m), 128'(0));
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t6_out_w%0d", i), 128'(ow_m), 128'(T4_EXP[i]));
         tick();
      end
      check("t6_busy_fall", 128'(busy_m), 128'(0));
      check("t6_err_final", 128'(err_m), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
